// File: rtl/raycast_pkg.sv
// Shared types and screen geometry for the raycaster write path.
// Wall shading is selected by the SHADE_EN macro in column_pixel_writer.
package raycast_pkg;

    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 180;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        WAIT_SWAP
    } writer_state_t;

    function automatic rgb565_t shade_half(rgb565_t c);
        rgb565_t s;
        s.r = c.r >> 1;
        s.g = c.g >> 1;
        s.b = c.b >> 1;
        return s;
    endfunction

endpackage

// File: rtl/column_span_calc.sv
// Clamps a wall height to the screen and centres it vertically.
// Any odd leftover row lands below the wall, on the floor.
module column_span_calc
    import raycast_pkg::*;
#(
    parameter int SCREEN_HEIGHT = raycast_pkg::SCREEN_HEIGHT
) (
    input  logic [7:0] height,
    output logic [7:0] draw_start,
    output logic [7:0] draw_end
);

    localparam logic [7:0] H_MAX = 8'(SCREEN_HEIGHT);

    logic [7:0] h;
    logic [7:0] gap;

    always_comb begin
        h          = (height > H_MAX) ? H_MAX : height;
        gap        = H_MAX - h;
        draw_start = gap >> 1;
        draw_end   = draw_start + h;
    end

endmodule

// File: rtl/column_pixel_writer.sv
// Expands column descriptors into per-pixel frame buffer writes.
// Define SHADE_EN to darken y-side walls by halving each channel.
module column_pixel_writer
    import raycast_pkg::*;
#(
    parameter int                     PIXEL_WIDTH   = 16,
    parameter int                     SCREEN_WIDTH  = raycast_pkg::SCREEN_WIDTH,
    parameter int                     SCREEN_HEIGHT = raycast_pkg::SCREEN_HEIGHT,
    parameter logic [PIXEL_WIDTH-1:0] CEIL_COLOR    = 16'h4208,
    parameter logic [PIXEL_WIDTH-1:0] FLOOR_COLOR   = 16'h8410
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_n_in,
    input  logic                   col_valid_in,
    output logic                   col_ready_out,
    input  logic [8:0]             col_x_in,
    input  logic [7:0]             col_height_in,
    input  logic [PIXEL_WIDTH-1:0] col_color_in,
    input  logic                   col_side_in,
    input  logic                   col_last_in,
    input  logic                   fb_swap_in,
    output logic                   ray_valid_out,
    output logic [15:0]            ray_address_out,
    output logic [PIXEL_WIDTH-1:0] ray_pixel_out,
    output logic                   ray_last_pixel_out,
    output logic                   busy_out
);

    localparam logic [8:0]  X_LIMIT  = 9'(SCREEN_WIDTH);
    localparam logic [15:0] ROW_STEP = 16'(SCREEN_WIDTH);
    localparam logic [7:0]  LAST_ROW = 8'(SCREEN_HEIGHT - 1);

    writer_state_t state, state_next;

    logic [7:0]             row;
    logic [15:0]            addr;
    logic [7:0]             start_q, end_q;
    logic [PIXEL_WIDTH-1:0] wall_q;
    logic                   last_q;

    logic [7:0]             span_start, span_end;
    logic [PIXEL_WIDTH-1:0] wall_in;
    logic [PIXEL_WIDTH-1:0] pixel_sel;
    logic                   accept;
    logic                   x_oob;

    column_span_calc #(
        .SCREEN_HEIGHT (SCREEN_HEIGHT)
    ) u_span (
        .height     (col_height_in),
        .draw_start (span_start),
        .draw_end   (span_end)
    );

`ifdef SHADE_EN
    assign wall_in = col_side_in ? PIXEL_WIDTH'(shade_half(rgb565_t'(col_color_in)))
                                 : col_color_in;
`else
    logic side_unused;
    assign side_unused = col_side_in;
    assign wall_in     = col_color_in;
`endif

    assign col_ready_out = (state == IDLE);
    assign busy_out      = (state != IDLE);
    assign accept        = col_valid_in && col_ready_out;
    assign x_oob         = (col_x_in >= X_LIMIT);

    always_comb begin
        pixel_sel = FLOOR_COLOR;
        if (row < start_q)
            pixel_sel = CEIL_COLOR;
        else if (row < end_q)
            pixel_sel = wall_q;
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A swap seen while the last pixel is still on the bus belongs to the
    // previous frame, so it must not release the wait.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (x_oob)
                        state_next = col_last_in ? WAIT_SWAP : IDLE;
                    else
                        state_next = DRAW;
                end
            end
            DRAW: begin
                if (row == LAST_ROW)
                    state_next = last_q ? WAIT_SWAP : IDLE;
            end
            WAIT_SWAP: begin
                if (fb_swap_in && !ray_last_pixel_out)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            row                <= '0;
            addr               <= '0;
            start_q            <= '0;
            end_q              <= '0;
            wall_q             <= '0;
            last_q             <= 1'b0;
            ray_valid_out      <= 1'b0;
            ray_address_out    <= '0;
            ray_pixel_out      <= '0;
            ray_last_pixel_out <= 1'b0;
        end else begin
            ray_valid_out      <= 1'b0;
            ray_last_pixel_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        row     <= '0;
                        addr    <= {7'b0, col_x_in};
                        start_q <= span_start;
                        end_q   <= span_end;
                        wall_q  <= wall_in;
                        last_q  <= col_last_in;
                        if (x_oob && col_last_in) begin
                            ray_valid_out      <= 1'b1;
                            ray_last_pixel_out <= 1'b1;
                            ray_address_out    <= '0;
                            ray_pixel_out      <= FLOOR_COLOR;
                        end
                    end
                end
                DRAW: begin
                    ray_valid_out      <= 1'b1;
                    ray_address_out    <= addr;
                    ray_pixel_out      <= pixel_sel;
                    ray_last_pixel_out <= last_q && (row == LAST_ROW);
                    row                <= row + 8'd1;
                    addr               <= addr + ROW_STEP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_column_pixel_writer.sv
// Directed self-checking bench for column_pixel_writer.
// Wall shading expectation follows the SHADE_EN macro.
module tb_column_pixel_writer;

    localparam logic [15:0] CEIL  = 16'h4208;
    localparam logic [15:0] FLOOR = 16'h8410;
`ifdef SHADE_EN
    localparam logic [15:0] SHADE_EXP = 16'h7BEF;
`else
    localparam logic [15:0] SHADE_EXP = 16'hFFFF;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        col_valid;
    logic        col_ready_out;
    logic [8:0]  col_x;
    logic [7:0]  col_height;
    logic [15:0] col_color;
    logic        col_side;
    logic        col_last;
    logic        fb_swap;
    logic        ray_valid_out;
    logic [15:0] ray_address_out;
    logic [15:0] ray_pixel_out;
    logic        ray_last_pixel_out;
    logic        busy_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    column_pixel_writer dut (
        .pixel_clk_in       (clk),
        .rst_n_in           (rst_n),
        .col_valid_in       (col_valid),
        .col_ready_out      (col_ready_out),
        .col_x_in           (col_x),
        .col_height_in      (col_height),
        .col_color_in       (col_color),
        .col_side_in        (col_side),
        .col_last_in        (col_last),
        .fb_swap_in         (fb_swap),
        .ray_valid_out      (ray_valid_out),
        .ray_address_out    (ray_address_out),
        .ray_pixel_out      (ray_pixel_out),
        .ray_last_pixel_out (ray_last_pixel_out),
        .busy_out           (busy_out)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [8:0] x, input logic [7:0] h,
                        input logic [15:0] c, input logic side, input logic last);
        int n = 0;
        @(negedge clk);
        col_valid  = 1'b1;
        col_x      = x;
        col_height = h;
        col_color  = c;
        col_side   = side;
        col_last   = last;
        while (!col_ready_out && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk1("handshake_ready", col_ready_out, 1'b1);
        @(posedge clk);
        #1;
        col_valid = 1'b0;
    endtask

    task automatic run_column(input int x, input int h, input logic [15:0] wall,
                              input logic last, input int swap_a, input int swap_b,
                              input int stop_row);
        int hc, s, e;
        logic [15:0] pix;
        hc = (h > 180) ? 180 : h;
        s  = (180 - hc) / 2;
        e  = s + hc;
        for (int r = 0; r < 180; r++) begin
            @(posedge clk);
            #1;
            fb_swap = (r == swap_a) || (r == swap_b);
            pix = (r < s) ? CEIL : (r < e) ? wall : FLOOR;
            chk1("pix_valid", ray_valid_out, 1'b1);
            chk16("pix_addr", ray_address_out, 16'(x + 320 * r));
            chk16("pix_color", ray_pixel_out, pix);
            chk1("pix_last", ray_last_pixel_out, last && (r == 179));
            if (r == stop_row) return;
        end
        @(posedge clk);
        #1;
        fb_swap = 1'b0;
        chk1("after_col_valid", ray_valid_out, 1'b0);
        chk1("after_col_last", ray_last_pixel_out, 1'b0);
    endtask

    task automatic pulse_swap();
        @(negedge clk);
        fb_swap = 1'b1;
        @(negedge clk);
        fb_swap = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        col_valid  = 1'b0;
        col_x      = '0;
        col_height = '0;
        col_color  = '0;
        col_side   = 1'b0;
        col_last   = 1'b0;
        fb_swap    = 1'b0;

        #3;
        chk1("rst_ready", col_ready_out, 1'b1);
        chk1("rst_valid", ray_valid_out, 1'b0);
        chk1("rst_busy", busy_out, 1'b0);
        chk1("rst_last", ray_last_pixel_out, 1'b0);
        chk16("rst_addr", ray_address_out, 16'h0000);
        chk16("rst_pixel", ray_pixel_out, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        send(9'd5, 8'd60, 16'hF800, 1'b0, 1'b0);
        run_column(5, 60, 16'hF800, 1'b0, -1, -1, -1);
        chk1("col1_ready", col_ready_out, 1'b1);
        chk1("col1_busy", busy_out, 1'b0);

        send(9'd319, 8'd200, 16'h07E0, 1'b0, 1'b1);
        run_column(319, 200, 16'h07E0, 1'b1, -1, -1, -1);
        repeat (48) @(posedge clk);
        #1;
        chk1("wait50_ready", col_ready_out, 1'b0);
        chk1("wait50_busy", busy_out, 1'b1);
        pulse_swap();
        chk1("swap_ready", col_ready_out, 1'b1);
        chk1("swap_busy", busy_out, 1'b0);

        send(9'd0, 8'd0, 16'h001F, 1'b0, 1'b0);
        run_column(0, 0, 16'h001F, 1'b0, -1, -1, -1);
        chk1("h0_ready", col_ready_out, 1'b1);

        send(9'd0, 8'd1, 16'h001F, 1'b0, 1'b1);
        run_column(0, 1, 16'h001F, 1'b1, 50, 179, -1);
        repeat (10) @(posedge clk);
        #1;
        chk1("ignored_swap_ready", col_ready_out, 1'b0);
        chk1("ignored_swap_busy", busy_out, 1'b1);
        pulse_swap();
        chk1("late_swap_ready", col_ready_out, 1'b1);

        send(9'd10, 8'd200, 16'hFFFF, 1'b1, 1'b0);
        run_column(10, 200, SHADE_EXP, 1'b0, -1, -1, -1);

        send(9'd400, 8'd50, 16'h1234, 1'b0, 1'b0);
        chk1("oob_valid0", ray_valid_out, 1'b0);
        @(posedge clk);
        #1;
        chk1("oob_valid1", ray_valid_out, 1'b0);
        chk1("oob_ready", col_ready_out, 1'b1);

        send(9'd320, 8'd50, 16'h1234, 1'b0, 1'b1);
        chk1("oobl_valid", ray_valid_out, 1'b1);
        chk1("oobl_last", ray_last_pixel_out, 1'b1);
        chk16("oobl_addr", ray_address_out, 16'h0000);
        chk16("oobl_pixel", ray_pixel_out, FLOOR);
        @(posedge clk);
        #1;
        chk1("oobl_valid_after", ray_valid_out, 1'b0);
        chk1("oobl_ready", col_ready_out, 1'b0);
        pulse_swap();
        chk1("oobl_swap_ready", col_ready_out, 1'b1);

        send(9'd7, 8'd40, 16'hABCD, 1'b0, 1'b0);
        run_column(7, 40, 16'hABCD, 1'b0, -1, -1, 100);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_valid", ray_valid_out, 1'b0);
        chk1("mid_rst_last", ray_last_pixel_out, 1'b0);
        chk16("mid_rst_addr", ray_address_out, 16'h0000);
        chk16("mid_rst_pixel", ray_pixel_out, 16'h0000);
        chk1("mid_rst_ready", col_ready_out, 1'b1);
        chk1("mid_rst_busy", busy_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        send(9'd2, 8'd100, 16'h5555, 1'b0, 1'b0);
        run_column(2, 100, 16'h5555, 1'b0, -1, -1, -1);
        chk1("final_ready", col_ready_out, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/column_pixel_writer.md
Name: column_pixel_writer

Overview:
- Write-side producer for the double-buffered frame buffer.
- Accepts one column descriptor per ray from the DDA stage: column x, wall line height, wall colour, and a last-column flag.
- Expands each descriptor into SCREEN_HEIGHT single-pixel writes (ceiling / wall / floor), one per clock, as an address/pixel/last stream.
- After the final pixel of a frame, stalls until the frame buffer reports a buffer swap, so no pixel is written into a buffer being displayed.

Parameters:
- PIXEL_WIDTH, 16, RGB565 pixel width.
- SCREEN_WIDTH, 320, columns in the low-res render target.
- SCREEN_HEIGHT, 180, rows in the low-res render target.
- CEIL_COLOR, 16'h4208, RGB565 ceiling colour.
- FLOOR_COLOR, 16'h8410, RGB565 floor colour.

Ports:
- pixel_clk_in  input  1  pixel clock; the only clock.
- rst_n_in  input  1  asynchronous active-low reset.
- col_valid_in  input  1  column descriptor valid.
- col_ready_out  output  1  descriptor accepted when valid & ready.
- col_x_in  input  9  column index, 0..SCREEN_WIDTH-1.
- col_height_in  input  8  wall line height in rows.
- col_color_in  input  16  wall colour, RGB565.
- col_side_in  input  1  wall face is the y-side (shading, see SHADE_EN).
- col_last_in  input  1  this is the final column of the frame.
- fb_swap_in  input  1  one-cycle pulse from the frame buffer on state toggle.
- ray_valid_out  output  1  address/pixel valid this cycle.
- ray_address_out  output  16  x + SCREEN_WIDTH*y.
- ray_pixel_out  output  16  RGB565 pixel.
- ray_last_pixel_out  output  1  final pixel of the frame; coincident with ray_valid_out.
- busy_out  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0 except col_ready_out=1.
  - Reset mid-column or mid-wait abandons the frame; no last pixel is emitted.
- States: IDLE, DRAW, WAIT_SWAP.
- IDLE:
  - col_ready_out=1.
  - On valid&ready, latch the descriptor, row=0, addr=col_x_in, then go to DRAW.
  - Latch arithmetic:
    - h = min(col_height_in, SCREEN_HEIGHT).
    - draw_start = (SCREEN_HEIGHT-h)>>1.
    - draw_end = draw_start+h, exclusive.
- DRAW:
  - col_ready_out=0.
  - Each cycle, register ray_valid_out=1, ray_address_out=addr, and ray_pixel_out as:
    - CEIL_COLOR if row<draw_start,
    - wall colour if draw_start<=row<draw_end,
    - FLOOR_COLOR otherwise.
  - Then row+=1 and addr+=SCREEN_WIDTH. Addresses are computed incrementally; no multiplier.
  - On row==SCREEN_HEIGHT-1:
    - ray_last_pixel_out = latched last flag.
    - Next state is WAIT_SWAP if last, else IDLE.
- Latency and throughput:
  - Handshake accepted at cycle N → first pixel valid at N+1, last pixel of the column at N+SCREEN_HEIGHT.
  - Throughput is SCREEN_HEIGHT+1 cycles per column.
- WAIT_SWAP:
  - col_ready_out=0, ray_valid_out=0.
  - On fb_swap_in go to IDLE.
  - A fb_swap_in in any other state is ignored.
  - fb_swap_in arriving in the same cycle as the last pixel is ignored; the block still waits for the next pulse.
- ray_valid_out=0 in IDLE and WAIT_SWAP; address/pixel hold their last value.
- Boundary cases:
  - h=0: whole column is ceiling/floor, with draw_start=draw_end=SCREEN_HEIGHT/2.
  - h>=SCREEN_HEIGHT: whole column is wall.
  - Odd gap: the extra row goes to floor.
- col_x_in >= SCREEN_WIDTH: descriptor is accepted and consumed (col_ready_out pulses normally) but no pixels are emitted (ray_valid_out stays 0). If col_last_in is set, go straight to WAIT_SWAP, with one cycle of ray_valid_out=1, ray_last_pixel_out=1 at address 0 carrying FLOOR_COLOR.
- Columns may arrive in any x order. The block does not check frame completeness.

Optional Feature:
- Macro: SHADE_EN.
- Defined: when col_side_in=1, the wall colour is halved per channel, i.e. {r>>1, g>>1, b>>1} packed back to RGB565. Ceiling and floor are unaffected.
- Undefined: col_side_in is ignored and the wall colour passes through unchanged. Timing is identical in both builds.

Decomposition:
- Package raycast_pkg holds:
  - typedef rgb565_t (16-bit packed struct r5/g6/b5);
  - SCREEN_WIDTH/SCREEN_HEIGHT localparams;
  - typedef writer_state_t enum {IDLE, DRAW, WAIT_SWAP};
  - function shade_half(rgb565_t).
- One sub-module: column_span_calc, combinational clamp and draw_start/draw_end from height. Its outputs are registered at latch time.

Test Plan:
- Column x=5, h=60, colour 16'hF800, last=0:
  - 180 valid cycles starting 1 cycle after handshake.
  - Rows 0–59 are CEIL_COLOR at addresses 5, 325, …, 18885.
  - Rows 60–119 are 16'hF800, starting at address 19205.
  - Rows 120–179 are FLOOR_COLOR, ending at address 57285.
  - No last pulse; returns to IDLE with col_ready_out=1.
- Column x=319, h=200, last=1:
  - All 180 pixels are wall colour; final address 57599 with ray_last_pixel_out=1.
  - col_ready_out stays 0 until an fb_swap_in pulse 50 cycles later; 1 the cycle after.
- h=0 and h=1 at x=0:
  - h=0: rows 0–89 ceiling, rows 90–179 floor.
  - h=1: draw_start=89, single wall pixel at address 28480.
- fb_swap_in pulsed during DRAW and on the same cycle as the last pixel: both ignored; the block remains in WAIT_SWAP until a later pulse.
- rst_n_in low at row 100 of a column: outputs 0 asynchronously, col_ready_out=1; the next column restarts at row 0.
- SHADE_EN, colour 16'hFFFF, side=1: wall pixels are 16'h7BEF. Without the macro: 16'hFFFF.
